// File: rtl/fnd_scan_driver_pkg.sv
// rtl/fnd_scan_driver_pkg.sv - shared state encoding, blank code and hex decode table for the FND scan driver
//   Contents: fnd_state_e (IDLE/BLANK/DRIVE), SEG_OFF (active-high all-dark), hex_to_seg() gfedcba table.
package fnd_scan_driver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } fnd_state_e;

  // Active-high "all segments dark"; polarity is applied by the top after decode.
  localparam logic [6:0] SEG_OFF = 7'h00;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    logic [6:0] seg;
    seg = SEG_OFF;
    case (hex)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = SEG_OFF;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/fnd_scan_driver_if.sv
// rtl/fnd_scan_driver_if.sv - strobe/digit inputs and segment/common outputs of the FND scan driver
//   fnd_clk     scan strobe (asynchronous level)
//   digit_val   hex nibble per digit, digit i = [4i+3:4i]
//   dp_mask     decimal point lit per digit
//   blank_mask  digit dark per digit
//   seg_data    [6:0]=g..a, [7]=dp
//   seg_com     digit common enables
//   frame_start one-cycle pulse when the inputs are latched
//   master: source of strobe/digits, sink of display lines; slave: the driver.
interface fnd_scan_driver_if #(
  parameter int NUM_DIGITS = 8
) ();
  logic                    fnd_clk;
  logic [4*NUM_DIGITS-1:0] digit_val;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [7:0]              seg_data;
  logic [NUM_DIGITS-1:0]   seg_com;
  logic                    frame_start;

  modport master (
    output fnd_clk, digit_val, dp_mask, blank_mask,
    input  seg_data, seg_com, frame_start
  );

  modport slave (
    input  fnd_clk, digit_val, dp_mask, blank_mask,
    output seg_data, seg_com, frame_start
  );
endinterface

// File: rtl/fnd_scan_driver_seg7_hex_decoder.sv
// rtl/fnd_scan_driver_seg7_hex_decoder.sv - combinational hex nibble to active-high gfedcba decoder
//   hex  in  4  nibble to display
//   seg  out 7  segments g..a, 1 = lit
module seg7_hex_decoder
  import fnd_scan_driver_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  assign seg = hex_to_seg(hex);
endmodule

// File: rtl/fnd_scan_driver.sv
// rtl/fnd_scan_driver.sv - multiplexed 7-segment scan driver strobed by the divider's fnd_clk
//   clock_50m in  system clock
//   rst       in  asynchronous active-low reset
//   bus       slave modport: fnd_clk/digit_val/dp_mask/blank_mask in, seg_data/seg_com/frame_start out
module fnd_scan_driver
  import fnd_scan_driver_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int BLANK_CYCLES   = 4,
  parameter int COM_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic         clock_50m,
  input  logic         rst,
  fnd_scan_driver_if.slave bus
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0]      IDX_LAST    = IDX_W'(NUM_DIGITS - 1);
  localparam logic [7:0]            BLANK_LOAD  = BLANK_CYCLES[7:0];
  localparam logic [NUM_DIGITS-1:0] COM_OFF     = {NUM_DIGITS{(COM_ACTIVE_LOW != 0)}};
  localparam logic [7:0]            SEG_OFF_OUT = {8{(SEG_ACTIVE_LOW != 0)}};
  localparam logic [NUM_DIGITS-1:0] ONE_HOT_0   = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

  logic [2:0]              sync_q, sync_d;
  fnd_state_e              state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] dig_sh_q, dig_sh_d;
  logic [NUM_DIGITS-1:0]   dp_sh_q, dp_sh_d;
  logic [NUM_DIGITS-1:0]   blank_sh_q, blank_sh_d;
  logic                    frame_start_q, frame_start_d;
  logic [NUM_DIGITS-1:0]   seg_com_q, seg_com_d;
  logic [7:0]              seg_data_q, seg_data_d;

  logic       tick;
  logic [3:0] nib;
  logic [6:0] seg_raw;

  // Three-stage shift: first two stages resolve metastability, third gives the edge reference.
  assign sync_d = {sync_q[1:0], bus.fnd_clk};
  assign tick   = sync_q[1] & ~sync_q[2];

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    dig_sh_d      = dig_sh_q;
    dp_sh_d       = dp_sh_q;
    blank_sh_d    = blank_sh_q;
    frame_start_d = 1'b0;
    if (tick) begin
      // A tick in any state advances the scan and restarts the gap, so it never stalls.
      state_d = ST_BLANK;
      cnt_d   = BLANK_LOAD;
      if (state_q == ST_IDLE || idx_q == IDX_LAST) begin
        idx_d         = '0;
        dig_sh_d      = bus.digit_val;
        dp_sh_d       = bus.dp_mask;
        blank_sh_d    = bus.blank_mask;
        frame_start_d = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end else if (state_q == ST_BLANK) begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == 8'd1) state_d = ST_DRIVE;
    end
  end

  // Decode from the next-state view so the output registers line up with the FSM.
  assign nib = dig_sh_d[{idx_d, 2'b00} +: 4];

  seg7_hex_decoder u_dec (
    .hex (nib),
    .seg (seg_raw)
  );

  always_comb begin
    seg_com_d  = COM_OFF;
    seg_data_d = SEG_OFF_OUT;
    if (state_d == ST_DRIVE) begin
      seg_com_d = (ONE_HOT_0 << idx_d) ^ COM_OFF;
      if (!blank_sh_d[idx_d]) seg_data_d = {dp_sh_d[idx_d], seg_raw} ^ SEG_OFF_OUT;
    end
  end

  always_ff @(posedge clock_50m or negedge rst) begin
    if (!rst) begin
      sync_q        <= '0;
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      cnt_q         <= '0;
      dig_sh_q      <= '0;
      dp_sh_q       <= '0;
      blank_sh_q    <= '0;
      frame_start_q <= 1'b0;
      seg_com_q     <= COM_OFF;
      seg_data_q    <= SEG_OFF_OUT;
    end else begin
      sync_q        <= sync_d;
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      dig_sh_q      <= dig_sh_d;
      dp_sh_q       <= dp_sh_d;
      blank_sh_q    <= blank_sh_d;
      frame_start_q <= frame_start_d;
      seg_com_q     <= seg_com_d;
      seg_data_q    <= seg_data_d;
    end
  end

  assign bus.seg_com     = seg_com_q;
  assign bus.seg_data    = seg_data_q;
  assign bus.frame_start = frame_start_q;

endmodule
